// File: rtl/ac_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ac_feeder_pkg
// Description : Shared types and helpers for the Aho-Corasick symbol feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package ac_feeder_pkg;

    localparam int c_SYM_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        SYM  = 2'd2,
        FIN  = 2'd3
    } feeder_state_t;

    // Requested run length, saturated to the buffer depth.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ac_symbol_buf.sv
`default_nettype none
// ============================================================================
// Module      : ac_symbol_buf
// Description : DEPTH x SYM_W text buffer, one write port, one async read port.
// Revision    : 1.0 - initial release
// ============================================================================
module ac_symbol_buf
    import ac_feeder_pkg::*;
#(
    parameter int SYM_W  = c_SYM_W,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [SYM_W-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [SYM_W-1:0]  o_rd_data
);

    // Contents deliberately survive reset so a loaded text can be replayed.
    logic [SYM_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/ac_symbol_feeder.sv
`default_nettype none
// ============================================================================
// Module      : ac_symbol_feeder
// Description : Plays a buffered text into the matcher as INIT/EN/STRING cycles.
//               Optional macro AC_FEEDER_HOLD_EN adds a HOLD input that freezes
//               the sequence and all outputs while high.
// Revision    : 1.0 - initial release
// ============================================================================
module ac_symbol_feeder
    import ac_feeder_pkg::*;
#(
    parameter int SYM_W  = c_SYM_W,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [SYM_W-1:0]  WR_DATA,
    input  logic              START,
    input  logic [ADDR_W:0]   LEN,
`ifdef AC_FEEDER_HOLD_EN
    input  logic              HOLD,
`endif
    output logic              EN_OUT,
    output logic              INIT_OUT,
    output logic [SYM_W-1:0]  STRING_OUT,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W:0]   SYM_CNT
);

    localparam int c_CNT_W = ADDR_W + 1;

    feeder_state_t      r_state;
    logic [c_CNT_W-1:0] r_len;
    logic [c_CNT_W-1:0] r_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_en;
    logic               r_init;
    logic               r_busy;
    logic               r_done;
    logic [SYM_W-1:0]   r_string;

    logic               w_advance;
    logic               w_wr_ok;
    logic [SYM_W-1:0]   w_rd_data;

`ifdef AC_FEEDER_HOLD_EN
    assign w_advance = ~HOLD;
`else
    assign w_advance = 1'b1;
`endif

    // The buffer only accepts writes outside a run so the played text is stable.
    assign w_wr_ok = WR_EN & ((r_state == IDLE) | (r_state == FIN));

    ac_symbol_buf #(
        .SYM_W  (SYM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk       (CLK),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (WR_ADDR),
        .i_wr_data (WR_DATA),
        .i_rd_addr (r_idx[ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_en     <= 1'b0;
            r_init   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_string <= '0;
        end else if (w_advance) begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_len <= c_CNT_W'(clamp_len(32'(LEN), DEPTH));
                        r_idx <= '0;
                        r_cnt <= '0;
                        if (LEN == '0) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= INIT;
                            r_init  <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                INIT: begin
                    r_state  <= SYM;
                    r_init   <= 1'b0;
                    r_en     <= 1'b1;
                    r_string <= w_rd_data;
                    r_idx    <= r_idx + c_CNT_W'(1);
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                end
                SYM: begin
                    r_en <= 1'b0;
                    // r_idx already points past the symbol just sent.
                    if (r_idx < r_len) begin
                        r_state <= INIT;
                        r_init  <= 1'b1;
                    end else begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_en    <= 1'b0;
                    r_init  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign EN_OUT     = r_en;
    assign INIT_OUT   = r_init;
    assign STRING_OUT = r_string;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign SYM_CNT    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ac_symbol_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ac_symbol_feeder
// Description : Self-checking bench for ac_symbol_feeder against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ac_symbol_feeder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WR_EN = 1'b0;
    logic [4:0] WR_ADDR = '0;
    logic [3:0] WR_DATA = '0;
    logic       START = 1'b0;
    logic [5:0] LEN = '0;
`ifdef AC_FEEDER_HOLD_EN
    logic       HOLD = 1'b0;
`endif
    logic       EN_OUT;
    logic       INIT_OUT;
    logic [3:0] STRING_OUT;
    logic       BUSY;
    logic       DONE;
    logic [5:0] SYM_CNT;

    int checks = 0;
    int errors = 0;

    // Reference state: buffer image and expected per-cycle outputs
    // packed as {EN, INIT, BUSY, DONE, STRING[3:0], SYM_CNT[5:0]}.
    logic [3:0]  tb_mem [32];
    logic [13:0] exp_vec [0:100];
    int          exp_len;
    logic [3:0]  last_str = 4'h0;
    int          last_cnt = 0;
    logic [13:0] obs;

    ac_symbol_feeder dut (
        .CLK        (CLK),
        .RST        (RST),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .START      (START),
        .LEN        (LEN),
`ifdef AC_FEEDER_HOLD_EN
        .HOLD       (HOLD),
`endif
        .EN_OUT     (EN_OUT),
        .INIT_OUT   (INIT_OUT),
        .STRING_OUT (STRING_OUT),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .SYM_CNT    (SYM_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    function automatic logic [13:0] sample();
        return {EN_OUT, INIT_OUT, BUSY, DONE, STRING_OUT, SYM_CNT};
    endfunction

    function automatic logic [13:0] idle_vec();
        return {4'b0000, last_str, 6'(last_cnt)};
    endfunction

    // Timeline after START at cycle t: odd offsets are INIT, even offsets carry
    // buf[k/2-1], offset 2N+1 is the DONE cycle.
    task automatic build_expect(input int len);
        int n;
        int c;
        logic [3:0] s;
        n = (len > 32) ? 32 : len;
        s = last_str;
        c = 0;
        exp_len = 2 * n + 1;
        for (int k = 1; k <= 2 * n; k++) begin
            if (k % 2 == 1) begin
                exp_vec[k] = {1'b0, 1'b1, 1'b1, 1'b0, s, 6'(c)};
            end else begin
                s = tb_mem[k/2-1];
                c = k / 2;
                exp_vec[k] = {1'b1, 1'b0, 1'b1, 1'b0, s, 6'(c)};
            end
        end
        exp_vec[2*n+1] = {1'b0, 1'b0, 1'b0, 1'b1, s, 6'(n)};
        last_str = s;
        last_cnt = n;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_sym(input int a, input logic [3:0] d);
        WR_EN   = 1'b1;
        WR_ADDR = 5'(a);
        WR_DATA = d;
        tick();
        WR_EN   = 1'b0;
        tb_mem[a] = d;
    endtask

    task automatic kick(input int len);
        START = 1'b1;
        LEN   = 6'(len);
        tick();
        START = 1'b0;
        WR_EN = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        obs = sample();
        checks++;
        if (obs !== 14'h0) begin
            errors++;
            $display("FAIL reset_init got %h exp %h", obs, 14'h0);
        end
        RST = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) write_sym(i, 4'($urandom_range(0, 15)));
        build_expect(6);
        kick(6);
        for (int k = 1; k <= 3; k++) begin
            obs = sample();
            checks++;
            if (obs !== exp_vec[k]) begin
                errors++;
                $display("FAIL reset_prerun cyc %0d got %h exp %h", k, obs, exp_vec[k]);
            end
            tick();
        end
        RST = 1'b1;
        tick();
        obs = sample();
        checks++;
        if (obs !== 14'h0) begin
            errors++;
            $display("FAIL reset_abort got %h exp %h", obs, 14'h0);
        end
        RST = 1'b0;
        last_str = 4'h0;
        last_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            obs = sample();
            checks++;
            if (obs !== 14'h0) begin
                errors++;
                $display("FAIL reset_nodone cyc %0d got %h exp %h", k, obs, 14'h0);
            end
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) write_sym(i, 4'(i + 1));
        build_expect(8);
        kick(8);
        for (int k = 1; k <= exp_len; k++) begin
            obs = sample();
            checks++;
            if (obs !== exp_vec[k]) begin
                errors++;
                $display("FAIL basic cyc %0d got %h exp %h", k, obs, exp_vec[k]);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            obs = sample();
            checks++;
            if (obs !== idle_vec()) begin
                errors++;
                $display("FAIL basic_hold cyc %0d got %h exp %h", k, obs, idle_vec());
            end
            tick();
        end
    endtask

    task automatic test_len_zero();
        build_expect(0);
        kick(0);
        obs = sample();
        checks++;
        if (obs !== exp_vec[1]) begin
            errors++;
            $display("FAIL len0_done got %h exp %h", obs, exp_vec[1]);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            obs = sample();
            checks++;
            if (obs !== idle_vec()) begin
                errors++;
                $display("FAIL len0_idle cyc %0d got %h exp %h", k, obs, idle_vec());
            end
        end
    endtask

    task automatic test_len_clamp();
        for (int i = 0; i < 32; i++) write_sym(i, 4'($urandom_range(0, 15)));
        build_expect(40);
        kick(40);
        for (int k = 1; k <= exp_len; k++) begin
            obs = sample();
            checks++;
            if (obs !== exp_vec[k]) begin
                errors++;
                $display("FAIL clamp cyc %0d got %h exp %h", k, obs, exp_vec[k]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int len;
        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(1, 6)) write_sym($urandom_range(0, 31), 4'($urandom_range(0, 15)));
            len = (r == 4) ? $urandom_range(33, 63) : $urandom_range(1, 32);
            build_expect(len);
            kick(len);
            for (int k = 1; k <= exp_len; k++) begin
                obs = sample();
                checks++;
                if (obs !== exp_vec[k]) begin
                    errors++;
                    $display("FAIL random run %0d len %0d cyc %0d got %h exp %h", r, len, k, obs, exp_vec[k]);
                end
                tick();
            end
        end
    endtask

    task automatic test_collision();
        build_expect(8);
        kick(8);
        for (int k = 1; k <= exp_len; k++) begin
            obs = sample();
            checks++;
            if (obs !== exp_vec[k]) begin
                errors++;
                $display("FAIL collide cyc %0d got %h exp %h", k, obs, exp_vec[k]);
            end
            WR_EN = (k == 3);
            WR_ADDR = 5'd2;
            WR_DATA = ~tb_mem[2];
            START = (k == 5) || (k == exp_len);
            LEN = 6'd3;
            tick();
        end
        START = 1'b0;
        WR_EN = 1'b0;
        for (int k = 0; k < 3; k++) begin
            obs = sample();
            checks++;
            if (obs !== idle_vec()) begin
                errors++;
                $display("FAIL fin_start cyc %0d got %h exp %h", k, obs, idle_vec());
            end
            tick();
        end
        build_expect(8);
        kick(8);
        for (int k = 1; k <= exp_len; k++) begin
            obs = sample();
            checks++;
            if (obs !== exp_vec[k]) begin
                errors++;
                $display("FAIL collide_next cyc %0d got %h exp %h", k, obs, exp_vec[k]);
            end
            tick();
        end
    endtask

    task automatic test_same_cycle();
        write_sym(0, 4'h0);
        WR_EN   = 1'b1;
        WR_ADDR = 5'd0;
        WR_DATA = 4'hF;
        tb_mem[0] = 4'hF;
        build_expect(3);
        kick(3);
        for (int k = 1; k <= exp_len; k++) begin
            obs = sample();
            checks++;
            if (obs !== exp_vec[k]) begin
                errors++;
                $display("FAIL same_cycle cyc %0d got %h exp %h", k, obs, exp_vec[k]);
            end
            tick();
        end
    endtask

`ifdef AC_FEEDER_HOLD_EN
    task automatic test_hold();
        int e;
        build_expect(4);
        kick(4);
        // Cycle 4 is a SYM cycle; it is seen once plus three frozen repeats.
        for (int c = 1; c <= exp_len + 3; c++) begin
            e = (c <= 4) ? c : ((c <= 7) ? 4 : c - 3);
            obs = sample();
            checks++;
            if (obs !== exp_vec[e]) begin
                errors++;
                $display("FAIL hold cyc %0d got %h exp %h", c, obs, exp_vec[e]);
            end
            HOLD = (c >= 4) && (c <= 6);
            tick();
        end
        HOLD = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_len_clamp();
        test_random();
        test_collision();
        test_same_cycle();
`ifdef AC_FEEDER_HOLD_EN
        test_hold();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
